// File: rtl/spi_peripheral_pkg.sv
// Shared constants for the SPI register peripheral: frame geometry and register map.
package spi_peripheral_pkg;

  localparam int         FRAME_BITS = 16;
  localparam int         CNT_W      = 5;
  localparam logic [4:0] CNT_SAT    = 5'd17;
  localparam int         NUM_REGS   = 5;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] MAX_ADDR         = 7'h04;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input, with a configurable reset value.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 register peripheral: 16-bit write frames load five 8-bit PWM control registers.
// Optional register readback on cipo is enabled by defining SPI_PERIPHERAL_READBACK_EN.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_d_reg, ncs_d_reg;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d_reg <= 1'b0;
      ncs_d_reg  <= 1'b1;
    end else begin
      sclk_d_reg <= sclk_s;
      ncs_d_reg  <= ncs_s;
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise, sample_en;
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign ncs_fall  = ~ncs_s & ncs_d_reg;
  assign ncs_rise  = ncs_s & ~ncs_d_reg;
  // A final sclk edge coincident with ncs rising still counts toward the frame.
  assign sample_en = sclk_rise & (~ncs_s | ncs_rise);

  logic [CNT_W-1:0]      count_reg, count_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;

  always_comb begin
    count_next = count_reg;
    shift_next = shift_reg;
    if (ncs_fall) begin
      count_next = '0;
      shift_next = '0;
    end else if (sample_en) begin
      shift_next = {shift_reg[FRAME_BITS-2:0], copi_s};
      if (count_reg != CNT_SAT) begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      count_reg <= count_next;
      shift_reg <= shift_next;
    end
  end

  logic       commit;
  logic [6:0] frame_addr;
  assign frame_addr = shift_next[14:8];
  assign commit = ncs_rise && (count_next == CNT_W'(FRAME_BITS)) &&
                  shift_next[15] && (frame_addr <= MAX_ADDR);

  logic [7:0] regs_reg [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= 8'h00;
        end else if (commit && (frame_addr == 7'(gi))) begin
          regs_reg[gi] <= shift_next[7:0];
        end
      end
    end
  endgenerate

  assign en_reg_out_7_0  = regs_reg[0];
  assign en_reg_out_15_8 = regs_reg[1];
  assign en_reg_pwm_7_0  = regs_reg[2];
  assign en_reg_pwm_15_8 = regs_reg[3];
  assign pwm_duty_cycle  = regs_reg[4];

`ifdef SPI_PERIPHERAL_READBACK_EN
  logic       sclk_fall, rd_load;
  logic [7:0] rd_data, tx_reg, tx_next;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign rd_load   = sample_en && !ncs_fall && (count_reg == 5'd7) && !shift_next[7];

  always_comb begin
    rd_data = 8'h00;
    case (shift_next[6:0])
      ADDR_EN_OUT_7_0:  rd_data = regs_reg[0];
      ADDR_EN_OUT_15_8: rd_data = regs_reg[1];
      ADDR_EN_PWM_7_0:  rd_data = regs_reg[2];
      ADDR_EN_PWM_15_8: rd_data = regs_reg[3];
      ADDR_PWM_DUTY:    rd_data = regs_reg[4];
      default:          rd_data = 8'h00;
    endcase
  end

  // The falling edge right after bit 8 must not shift, or the MSB is lost before bit 9 is sampled.
  always_comb begin
    tx_next = tx_reg;
    if (ncs_s) begin
      tx_next = 8'h00;
    end else if (rd_load) begin
      tx_next = rd_data;
    end else if (sclk_fall && (count_reg >= 5'd9) && (count_reg <= 5'd16)) begin
      tx_next = {tx_reg[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg <= 8'h00;
    end else begin
      tx_reg <= tx_next;
    end
  end

  assign cipo = tx_reg[7];
`else
  assign cipo = 1'b0;
`endif

endmodule
